// File: rtl/op_lut_table_arbiter.sv
// Shares one single-port LUT RAM between the datapath lookup engine and
// the host register port. The datapath wins ties; a streak bound limits host starvation.
module op_lut_table_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 96,
  parameter int RD_LAT       = 1,
  parameter int MAX_DP_BURST = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  dp_req,
  input  logic [ADDR_WIDTH-1:0] dp_addr,
  output logic                  dp_ack,
  output logic                  dp_rd_vld,
  output logic [DATA_WIDTH-1:0] dp_rd_data,
  input  logic                  reg_req,
  input  logic                  reg_rd_wr_L,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic                  reg_ack,
  output logic [DATA_WIDTH-1:0] reg_rd_data,
  output logic                  tbl_en,
  output logic                  tbl_we,
  output logic [ADDR_WIDTH-1:0] tbl_addr,
  output logic [DATA_WIDTH-1:0] tbl_wr_data,
  input  logic [DATA_WIDTH-1:0] tbl_rd_data
);

  localparam int SW = $clog2(MAX_DP_BURST + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DP_BURST);

  typedef enum logic [1:0] {
    REG_IDLE,
    REG_PEND,
    REG_WAIT
  } reg_st_e;

  reg_st_e st_q, st_d;
  logic                  rd_wr_L_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         streak_q, streak_d;
  logic [RD_LAT:0]       tag_dp_q, tag_reg_q;
  logic                  wr_ack_q;
  logic                  host_win;

  logic                  dp_rd_vld_q, reg_ack_q;
  logic [DATA_WIDTH-1:0] dp_rd_data_q, reg_rd_data_q;
  logic                  tbl_en_q, tbl_we_q;
  logic [ADDR_WIDTH-1:0] tbl_addr_q;
  logic [DATA_WIDTH-1:0] tbl_wr_data_q;

  assign host_win = (st_q == REG_PEND) & (~dp_req | (streak_q == SMAX));
  assign dp_ack   = dp_req & ~host_win;

  always_comb begin
    st_d     = st_q;
    streak_d = '0;
    unique case (st_q)
      REG_IDLE: if (reg_req) st_d = REG_PEND;
      REG_PEND: if (host_win) st_d = REG_WAIT;
      REG_WAIT: if (reg_ack_q) st_d = REG_IDLE;
      default:  st_d = REG_IDLE;
    endcase
    // streak only counts datapath wins that held off a pending host
    if (st_q == REG_PEND && !host_win) begin
      streak_d = streak_q;
      if (dp_ack && streak_q != SMAX) streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q      <= REG_IDLE;
      streak_q  <= '0;
      rd_wr_L_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      st_q     <= st_d;
      streak_q <= streak_d;
      if (st_q == REG_IDLE && reg_req) begin
        rd_wr_L_q <= reg_rd_wr_L;
        addr_q    <= reg_addr;
        wdata_q   <= reg_wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tbl_en_q      <= 1'b0;
      tbl_we_q      <= 1'b0;
      tbl_addr_q    <= '0;
      tbl_wr_data_q <= '0;
      tag_dp_q      <= '0;
      tag_reg_q     <= '0;
      wr_ack_q      <= 1'b0;
    end else begin
      tbl_en_q  <= dp_ack | host_win;
      tbl_we_q  <= host_win & ~rd_wr_L_q;
      wr_ack_q  <= host_win & ~rd_wr_L_q;
      tag_dp_q  <= {tag_dp_q[RD_LAT-1:0], dp_ack};
      tag_reg_q <= {tag_reg_q[RD_LAT-1:0], host_win & rd_wr_L_q};
      if (dp_ack) begin
        tbl_addr_q <= dp_addr;
      end else if (host_win) begin
        tbl_addr_q <= addr_q;
      end
      if (host_win) tbl_wr_data_q <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dp_rd_vld_q   <= 1'b0;
      dp_rd_data_q  <= '0;
      reg_ack_q     <= 1'b0;
      reg_rd_data_q <= '0;
    end else begin
      dp_rd_vld_q <= tag_dp_q[RD_LAT];
      reg_ack_q   <= wr_ack_q | tag_reg_q[RD_LAT];
      if (tag_dp_q[RD_LAT]) dp_rd_data_q <= tbl_rd_data;
      if (tag_reg_q[RD_LAT]) reg_rd_data_q <= tbl_rd_data;
    end
  end

  assign dp_rd_vld   = dp_rd_vld_q;
  assign dp_rd_data  = dp_rd_data_q;
  assign reg_ack     = reg_ack_q;
  assign reg_rd_data = reg_rd_data_q;
  assign tbl_en      = tbl_en_q;
  assign tbl_we      = tbl_we_q;
  assign tbl_addr    = tbl_addr_q;
  assign tbl_wr_data = tbl_wr_data_q;

endmodule

// File: tb/tb_op_lut_table_arbiter.sv
// Bench for op_lut_table_arbiter: write-first RAM model plus an
// event-scheduled reference model of grants and result delivery.
module tb_op_lut_table_arbiter;
  localparam int AW = 5;
  localparam int DW = 96;
  localparam int RL = 1;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          dp_req = 1'b0;
  logic [AW-1:0] dp_addr = '0;
  logic          dp_ack, dp_rd_vld;
  logic [DW-1:0] dp_rd_data;
  logic          reg_req = 1'b0;
  logic          reg_rd_wr_L = 1'b1;
  logic [AW-1:0] reg_addr = '0;
  logic [DW-1:0] reg_wr_data = '0;
  logic          reg_ack;
  logic [DW-1:0] reg_rd_data;
  logic          tbl_en, tbl_we;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_wr_data, tbl_rd_data;

  always #5 clk = ~clk;

  op_lut_table_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RL), .MAX_DP_BURST(MB)
  ) dut (
    .clk(clk), .resetn(resetn),
    .dp_req(dp_req), .dp_addr(dp_addr), .dp_ack(dp_ack),
    .dp_rd_vld(dp_rd_vld), .dp_rd_data(dp_rd_data),
    .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_ack(reg_ack), .reg_rd_data(reg_rd_data),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wr_data(tbl_wr_data), .tbl_rd_data(tbl_rd_data)
  );

  // write-first single-port RAM with RL-cycle read pipeline
  logic          ld = 1'b0;
  logic [AW-1:0] ld_a = '0;
  logic [DW-1:0] ld_d = '0;
  logic [DW-1:0] ram [32];
  logic [DW-1:0] rpipe [RL];
  assign tbl_rd_data = rpipe[RL-1];

  always @(posedge clk) begin
    if (ld) ram[ld_a] <= ld_d;
    else if (tbl_en && tbl_we) ram[tbl_addr] <= tbl_wr_data;
    if (tbl_en) rpipe[0] <= tbl_we ? tbl_wr_data : ram[tbl_addr];
    else rpipe[0] <= {3{32'hDEADBEEF}};
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [DW-1:0] mm [32];
  logic          q_dpv [16];
  logic [DW-1:0] q_dpd [16];
  logic          q_rack [16];
  logic          q_rrd [16];
  logic [DW-1:0] q_rdat [16];
  int            cyc = 0;
  int            hs = 0;
  int            streak = 0;
  logic          h_rd;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_data;
  logic          e_ten, e_twe;
  logic [AW-1:0] e_taddr;
  logic [DW-1:0] e_twd, e_dpd, e_rrd;
  logic          m_ack;
  logic          o_ack, o_dpv, o_rack, o_ten, o_twe;
  logic [AW-1:0] o_taddr;
  logic [DW-1:0] o_dpd, o_rrd;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      q_dpv[i] = 1'b0;
      q_rack[i] = 1'b0;
      q_rrd[i] = 1'b0;
      q_dpd[i] = '0;
      q_rdat[i] = '0;
    end
    hs = 0;
    streak = 0;
    h_rd = 1'b0;
    h_addr = '0;
    h_data = '0;
    e_ten = 1'b0;
    e_twe = 1'b0;
    e_taddr = '0;
    e_twd = '0;
    e_dpd = '0;
    e_rrd = '0;
    m_ack = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dpv"}, dp_rd_vld, 0);
    chk({tag, "_dpd"}, dp_rd_data, 0);
    chk({tag, "_rack"}, reg_ack, 0);
    chk({tag, "_rrd"}, reg_rd_data, 0);
    chk({tag, "_ten"}, tbl_en, 0);
    chk({tag, "_twe"}, tbl_we, 0);
    chk({tag, "_taddr"}, tbl_addr, 0);
    chk({tag, "_twd"}, tbl_wr_data, 0);
  endtask

  task automatic step(input logic dpr, input logic [AW-1:0] dpa,
                      input logic rr, input logic rw,
                      input logic [AW-1:0] ra, input logic [DW-1:0] rd);
    int s;
    logic hw, ea, rack;
    @(negedge clk);
    dp_req = dpr;
    dp_addr = dpa;
    reg_req = rr;
    reg_rd_wr_L = rw;
    reg_addr = ra;
    reg_wr_data = rd;
    #4;
    s = cyc % 16;
    if (q_dpv[s]) e_dpd = q_dpd[s];
    rack = q_rack[s];
    if (rack && q_rrd[s]) e_rrd = q_rdat[s];
    hw = (hs == 1) && (!dpr || streak == MB);
    ea = dpr && !hw;
    o_ack = dp_ack;
    o_dpv = dp_rd_vld;
    o_dpd = dp_rd_data;
    o_rack = reg_ack;
    o_rrd = reg_rd_data;
    o_ten = tbl_en;
    o_twe = tbl_we;
    o_taddr = tbl_addr;
    chk("dp_ack", dp_ack, ea);
    chk("dp_rd_vld", dp_rd_vld, q_dpv[s]);
    chk("dp_rd_data", dp_rd_data, e_dpd);
    chk("reg_ack", reg_ack, rack);
    chk("reg_rd_data", reg_rd_data, e_rrd);
    chk("tbl_en", tbl_en, e_ten);
    chk("tbl_we", tbl_we, e_twe);
    chk("tbl_addr", tbl_addr, e_taddr);
    chk("tbl_wr_data", tbl_wr_data, e_twd);
    e_ten = ea || hw;
    e_twe = hw && !h_rd;
    if (ea) begin
      e_taddr = dpa;
      q_dpv[(cyc + 2 + RL) % 16] = 1'b1;
      q_dpd[(cyc + 2 + RL) % 16] = mm[dpa];
    end else if (hw) begin
      e_taddr = h_addr;
    end
    if (hw) begin
      e_twd = h_data;
      if (h_rd) begin
        q_rack[(cyc + 2 + RL) % 16] = 1'b1;
        q_rrd[(cyc + 2 + RL) % 16] = 1'b1;
        q_rdat[(cyc + 2 + RL) % 16] = mm[h_addr];
      end else begin
        mm[h_addr] = h_data;
        q_rack[(cyc + 2) % 16] = 1'b1;
        q_rrd[(cyc + 2) % 16] = 1'b0;
      end
    end
    if (hs == 1 && !hw) begin
      if (ea && streak < MB) streak++;
    end else begin
      streak = 0;
    end
    case (hs)
      0: if (rr) begin
        hs = 1;
        h_rd = rw;
        h_addr = ra;
        h_data = rd;
      end
      1: if (hw) hs = 2;
      default: if (rack) hs = 0;
    endcase
    q_dpv[s] = 1'b0;
    q_rack[s] = 1'b0;
    m_ack = ea;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 1, '0, '0);
  endtask

  int            cnt_a, cnt_b;
  logic [7:0]    ackv;
  logic          t_we6, t_rack7;
  logic [AW-1:0] t_addr6;
  logic [DW-1:0] t_data;
  logic [AW-1:0] da;
  logic          dpr_r, hold;
  logic [AW-1:0] dpa_r;

  initial begin
    model_clear();
    #1;
    check_zero("rst0");
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      ld = 1'b1;
      ld_a = AW'(a);
      ld_d = (a == 3) ? DW'('hABC) : {$urandom, $urandom, $urandom};
      mm[a] = ld_d;
    end
    @(negedge clk);
    ld = 1'b0;
    resetn = 1'b1;

    // single lookup latency
    step(1, 3, 0, 1, 0, 0);
    chk("t1_ack", o_ack, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("t1_ten", o_ten, 1);
    chk("t1_taddr", o_taddr, 3);
    step(0, 0, 0, 1, 0, 0);
    chk("t1_vld_early", o_dpv, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t1_vld", o_dpv, 1);
    chk("t1_data", o_dpd, 'hABC);
    step(0, 0, 0, 1, 0, 0);
    chk("t1_vld_pulse", o_dpv, 0);
    idle(2);

    // back-to-back lookups
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) step(1, AW'(i), 0, 1, 0, 0);
      else step(0, 0, 0, 1, 0, 0);
      cnt_a += int'(o_ack);
      cnt_b += int'(o_dpv);
    end
    chk("t2_acks", cnt_a, 8);
    chk("t2_vlds", cnt_b, 8);

    // starvation bound with a host write
    da = 0;
    step(1, da, 1, 0, 5, 'h1234);
    if (m_ack) da++;
    ackv = '0;
    for (int k = 1; k <= 7; k++) begin
      step(1, da, 0, 1, 0, 0);
      if (m_ack) da++;
      ackv[k] = o_ack;
      if (k == 6) begin
        t_we6 = o_twe;
        t_addr6 = o_taddr;
      end
      if (k == 7) t_rack7 = o_rack;
    end
    chk("t3_burst", ackv[4:1], 4'hF);
    chk("t3_gap", ackv[5], 0);
    chk("t3_resume", ackv[6], 1);
    chk("t3_we", t_we6, 1);
    chk("t3_waddr", t_addr6, 5);
    chk("t3_rack", t_rack7, 1);
    idle(6);

    // host read-back, datapath idle
    step(0, 0, 1, 1, 5, 0);
    cnt_b = 0;
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 0, 1, 0, 0);
      cnt_b += int'(o_dpv);
      if (k == 3) chk("t4_rack_early", o_rack, 0);
      if (k == 4) begin
        chk("t4_rack", o_rack, 1);
        chk("t4_rdata", o_rrd, 'h1234);
      end
    end
    chk("t4_no_dpv", cnt_b, 0);

    // extra host requests while waiting are dropped
    cnt_a = 0;
    cnt_b = 0;
    step(0, 0, 1, 0, 9, 'h55);
    for (int k = 1; k <= 7; k++) begin
      step(0, 0, (k == 2 || k == 3), 0, 10, 'h66);
      cnt_a += int'(o_rack);
      cnt_b += int'(o_ten);
    end
    chk("t5_one_ack", cnt_a, 1);
    chk("t5_one_en", cnt_b, 1);

    // reset with a lookup in flight
    step(1, 7, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    resetn = 1'b0;
    dp_req = 1'b0;
    reg_req = 1'b0;
    #1;
    check_zero("rst1");
    model_clear();
    @(negedge clk);
    resetn = 1'b1;
    cnt_b = 0;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1, 0, 0);
      cnt_b += int'(o_dpv);
    end
    chk("t6_no_stale", cnt_b, 0);
    step(1, 3, 0, 1, 0, 0);
    cnt_b = 0;
    t_data = '0;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1, 0, 0);
      cnt_b += int'(o_dpv);
      if (o_dpv) t_data = o_dpd;
    end
    chk("t6_post_vld", cnt_b, 1);
    chk("t6_post_data", t_data, 'hABC);

    // randomized traffic
    hold = 1'b0;
    dpr_r = 1'b0;
    dpa_r = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        dpr_r = ($urandom_range(9) < 6);
        dpa_r = AW'($urandom);
      end
      step(dpr_r, dpa_r, ($urandom_range(9) == 0), 1'($urandom),
           AW'($urandom), {$urandom, $urandom, $urandom});
      hold = dpr_r && !m_ack;
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
